// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch front end.
// Issues sequential i-cache requests under a credit rule. Responses are buffered
// in a small FIFO that feeds decode. Redirect flushes the FIFO and restarts fetch
// at a new PC. Halt stops new requests while the FIFO keeps draining.
// Optional macro FETCH_PERF_EN adds fetch and stall performance counters.
//
// Handshake: decode takes the head entry in every cycle where inst_valid and
// inst_ready are both 1 at the rising edge. inst_valid does not depend on
// inst_ready. The i-cache answers exactly one cycle after ic_en, and only then.
module fetch_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        ic_en,
    output logic [31:0] ic_addr,
    input  logic [31:0] ic_rdata,
    input  logic        ic_rvalid,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic [1:0]  dbg_state
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CW1 = CW + 1;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [31:0]     mem_inst_q [DEPTH];
    logic [31:0]     mem_pc_q   [DEPTH];

    logic            credit_ok;
    logic            fetch_en;
    logic            push;
    logic            pop;

    // Credit: queued entries plus the outstanding request must leave room for one more.
    assign credit_ok = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < CW1'(DEPTH);
    assign fetch_en  = rst_n && (state_q == ST_RUN) && !halt && !redirect_valid && credit_ok;
    // Only a response to our own outstanding request is accepted, and never during a flush.
    assign push      = rst_n && ic_rvalid && inflight_q && !redirect_valid;
    assign pop       = (count_q != '0) && inst_ready && !redirect_valid;

    // Next-state logic: BOOT always lasts a single cycle, halt toggles RUN/HALTED.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (halt) state_d = ST_HALTED;
            ST_HALTED: if (!halt) state_d = ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
    end

    // Datapath next values: PC, outstanding request tracking, FIFO pointers and count.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = fetch_en;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (fetch_en) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + AW'(1);
            if (pop)  head_d = head_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // FIFO storage: contents are only observable through a valid head, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst_q[tail_q] <= ic_rdata;
            mem_pc_q[tail_q]   <= req_pc_q;
        end
    end

    assign ic_en      = fetch_en;
    assign ic_addr    = rst_n ? pc_q : 32'd0;
    assign inst_valid = rst_n && (count_q != '0);
    assign inst       = inst_valid ? mem_inst_q[head_q] : 32'd0;
    assign inst_pc    = inst_valid ? mem_pc_q[head_q] : 32'd0;
    assign dbg_state  = state_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        credit_stall;

    assign credit_stall = rst_n && (state_q == ST_RUN) && !halt && !redirect_valid && !credit_ok;

    // Performance counters: issued fetches and cycles lost to a full credit count.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_en};
        stall_cnt_d = stall_cnt_q + {31'd0, credit_stall};
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, fetch-queue entries (power of 2, >=2).
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports redirect_valid  in  1, redirect_pc  in  32  flush queue and restart fetch.
REQ-006 SHALL have port halt  in  1  stop issuing new fetches while held.
REQ-007 SHALL have ports ic_en  out  1, ic_addr  out  32  request to the i-cache.
REQ-008 SHALL have ports ic_rdata  in  32, ic_rvalid  in  1  i-cache response, one cycle after ic_en.
REQ-009 SHALL have ports inst_valid  out  1, inst  out  32, inst_pc  out  32, inst_ready  in  1  decode handshake.

Function
REQ-010 SHALL implement FSM BOOT, RUN, HALTED; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-011 RUN -> HALTED when halt=1; HALTED -> RUN when halt=0; redirect_valid is honoured in any state.
REQ-012 ic_en SHALL be combinational: 1 only in RUN, halt=0, redirect_valid=0, and (count + inflight) < DEPTH.
REQ-013 ic_addr SHALL equal the fetch PC; the PC SHALL advance by 4 on each cycle with ic_en=1 and wrap modulo 2^32.
REQ-014 inflight SHALL be a register set to ic_en each cycle; at most one request outstanding.
REQ-015 On ic_rvalid=1 with inflight=1 and no squash, {ic_rdata, request PC} SHALL be pushed into the queue at that edge.
REQ-016 inst_valid SHALL be 1 whenever the queue is non-empty; inst/inst_pc show the head entry; earliest inst_valid is two cycles after the ic_en cycle.
REQ-017 Pop SHALL occur when inst_valid and inst_ready are both 1; simultaneous push and pop SHALL leave count unchanged.
REQ-018 The queue SHALL never overflow; the credit rule of REQ-012 guarantees space for every response.
REQ-019 ic_rvalid=1 with inflight=0 SHALL be ignored.
REQ-020 On redirect_valid=1: queue cleared (count=0), any response arriving in that cycle discarded, ic_en=0, PC <= {redirect_pc[31:2], 2'b00}.
REQ-021 Redirect SHALL take priority over a same-cycle pop and push; fetch resumes from the new PC in the following cycle when state is RUN and halt=0.
REQ-022 While HALTED the queue SHALL continue to drain to decode, and the single outstanding response SHALL still be accepted.

Reset
REQ-023 While rst_n=0: state=BOOT, PC=RESET_PC, count=0, inflight=0, queue pointers=0.
REQ-024 While rst_n=0 all outputs SHALL be 0: ic_en, ic_addr, inst_valid, inst, inst_pc.
REQ-025 Reset asserted mid-operation SHALL discard queue contents and the pending response with no stale inst_valid afterwards.

Configuration
REQ-026 Macro FETCH_PERF_EN SHALL add outputs perf_fetch_cnt[31:0] (count of ic_en cycles) and perf_stall_cnt[31:0] (cycles in RUN with halt=0, redirect_valid=0 and ic_en=0 due to a full credit count).
REQ-027 Both counters SHALL reset to 0 and wrap at 2^32; without FETCH_PERF_EN these ports and their logic SHALL be absent and all other behaviour is identical.

Verification
REQ-028 Reset release with RESET_PC=0 and inst_ready=1 -> ic_addr sequence 0,4,8,... starts in the cycle after BOOT; first inst_valid two cycles later with inst_pc=0.
REQ-029 inst_ready=0 and DEPTH=4 -> exactly 4 entries are queued, ic_en is then 0, and no entry is lost or duplicated after inst_ready rises.
REQ-030 redirect_valid with redirect_pc=32'h0000_0102 while the queue is full and a response is in flight -> inst_valid=0 the next cycle, and the next fetched ic_addr=32'h0000_0100.
REQ-031 halt held for 5 cycles with 2 queued entries -> no ic_en, both entries delivered, fetch resumes at the next sequential PC after halt drops.
REQ-032 PC=32'hFFFF_FFFC fetch -> the next ic_addr is 32'h0000_0000.
REQ-033 rst_n pulsed low with 3 queued entries -> inst_valid=0 and count=0 after release, and fetch restarts at RESET_PC.
